step_display_ctrl: RTL and testbench
====================================

// Module: step_display_ctrl
// PURPOSE
//  Board-side companion to the multi-cycle CPU top, handling its I/O.
//  - Debounces the single-step push-button and produces the CPU step clock.
//  - Consumes the CPU's observation buses (PC, next PC, register reads, ALU result, DB).
//  - Drives a 4-digit, multiplexed, active-low 7-segment display, showing one byte pair selected by switches.
// PARAMETERS
//  SCAN_DIV         100000   CLK cycles each digit stays lit (>=2)
//  DEBOUNCE_CYCLES  1000000  cycles the synchronised button must stay stable before being accepted (>=2)
// PORTS
//  CLK         in   1   board clock; all state on rising edge
//  RST         in   1   asynchronous, active-low reset
//  step_btn    in   1   raw push-button, asynchronous to CLK
//  mode_sel    in   2   display select switches
//  rs_num      in   5   rs field of current instruction
//  rt_num      in   5   rt field of current instruction
//  addr        in   32  current PC
//  next_PC     in   32  next PC
//  ReadData1   in   32  register file port 1
//  ReadData2   in   32  register file port 2
//  result      in   32  ALU result
//  DB          in   32  writeback bus
//  cpu_clk     out  1   debounced button level; this is the CPU's CLK
//  step_pulse  out  1   one-CLK pulse on each accepted press
//  an          out  4   digit enables, active-low; an[0] = rightmost digit
//  seg         out  8   {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (RST=0), asynchronous:
//   - an=4'b1111, seg=8'hFF, cpu_clk=0, step_pulse=0
//   - all counters=0, digit index=0, display latch disp[15:0]=16'h0000
//  Debounce:
//   - step_btn passes through a 2-FF synchroniser, giving sync.
//   - dcnt clears whenever sync==cpu_clk; otherwise it increments.
//   - When dcnt reaches DEBOUNCE_CYCLES-1: cpu_clk<=sync and dcnt<=0.
//   - step_pulse=1 for exactly one cycle, registered with the cpu_clk 0->1 update.
//   - A bounce shorter than DEBOUNCE_CYCLES produces no edge; a held button produces exactly one pulse.
//  Scan:
//   - scnt counts 0..SCAN_DIV-1 and wraps.
//   - On wrap, the 2-bit digit index idx increments (3 wraps to 0).
//  Frame latch:
//   - In the cycle where scnt==SCAN_DIV-1 and idx==3, disp loads the selected pair for the current mode_sel.
//   - mode 00: {addr[7:0], next_PC[7:0]}
//   - mode 01: {3'b0,rs_num, ReadData1[7:0]}
//   - mode 10: {3'b0,rt_num, ReadData2[7:0]}
//   - mode 11: {result[7:0], DB[7:0]}
//   - Changes to mode_sel or the data buses mid-frame appear only at the next frame boundary, so the digits are never torn.
//   - The first frame after reset shows 0000.
//  Outputs (registered, 1-cycle latency from idx/disp):
//   - an: idx0=1110 shows disp[3:0]; idx1=1101 shows disp[7:4]; idx2=1011 shows disp[11:8]; idx3=0111 shows disp[15:12].
//   - seg[7]=1 (dp off).
//   - seg[6:0] hex patterns: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  Reset mid-operation:
//   - All state clears immediately, including cpu_clk.
//   - If the button is still held at release, one step_pulse follows DEBOUNCE_CYCLES+2 cycles later.
//   - A press in progress is never lost silently and never duplicated.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_CYCLES=8)
//  1. Reset: RST=0 -> an=1111, seg=FF, cpu_clk=0. Release RST -> next edge gives an=1110, seg=C0.
//  2. mode 00, addr=32'h14, next_PC=32'h18, run one full frame (16 cycles).
//     -> Next frame shows an0=80('8'), an1=F9('1'), an2=99('4'), an3=F9('1').
//  3. Button bounces high for 5 cycles, then low -> no step_pulse, cpu_clk stays 0.
//     Button held for 30 cycles -> exactly one step_pulse, 10 cycles after the press.
//     Release -> cpu_clk falls 10 cycles after release, with no pulse.
//  4. mode 11, result=8'hAB, DB=8'hCD -> digits show A1('d'), C6('C'), 83('b'), 88('A').
//     Switch to mode 01 at idx=1 -> old digits remain until the frame wraps.
//  5. mode 01, rs_num=5'd31, ReadData1=32'hFF -> digits F,F,F,1 (0E,0E,0E,79).
//  6. Assert RST while the button is held mid-debounce; release with the button still held.
//     -> cpu_clk=0 during reset, then one step_pulse 10 cycles after release.

Source files
------------

// File: rtl/step_display_ctrl.sv
// step_display_ctrl
//   Board-side I/O companion for the multi-cycle CPU. It debounces the
//   single-step push-button into the CPU clock, and shows one byte pair of the
//   CPU's observation buses on a 4-digit multiplexed 7-segment display.
//
// Ports
//   CLK         in   board clock, all state on the rising edge
//   RST         in   asynchronous active-low reset
//   step_btn    in   raw push-button, asynchronous to CLK
//   mode_sel    in   [1:0] display select: 00 PC/nextPC, 01 rs/RD1, 10 rt/RD2, 11 ALU/DB
//   rs_num      in   [4:0] rs field of the current instruction
//   rt_num      in   [4:0] rt field of the current instruction
//   addr        in   [31:0] current PC
//   next_PC     in   [31:0] next PC
//   ReadData1   in   [31:0] register file port 1
//   ReadData2   in   [31:0] register file port 2
//   result      in   [31:0] ALU result
//   DB          in   [31:0] writeback bus
//   cpu_clk     out  debounced button level, drives the CPU clock
//   step_pulse  out  one-CLK pulse on each accepted press
//   an          out  [3:0] digit enables, active-low, an[0] = rightmost digit
//   seg         out  [7:0] {dp,g,f,e,d,c,b,a}, active-low
module step_display_ctrl #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        step_btn,
  input  logic [1:0]  mode_sel,
  input  logic [4:0]  rs_num,
  input  logic [4:0]  rt_num,
  input  logic [31:0] addr,
  input  logic [31:0] next_PC,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] result,
  input  logic [31:0] DB,
  output logic        cpu_clk,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE  = SW'(1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);

  // Active-low segment pattern {g..a} for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic          sync_meta_r;
  logic          sync_r;
  logic [DW-1:0] dcnt_r;
  logic          cpu_clk_r;
  logic          step_pulse_r;
  logic [SW-1:0] scnt_r;
  logic [1:0]    idx_r;
  logic [15:0]   disp_r;
  logic [3:0]    an_r;
  logic [7:0]    seg_r;

  logic          scan_wrap_s;
  logic [15:0]   pair_s;
  logic [3:0]    nib_s;
  logic [3:0]    an_nxt_s;
  logic [7:0]    seg_nxt_s;
  logic          unused_bus_s;

  // Only the low byte of each wide bus is ever displayed.
  assign unused_bus_s = ^{addr[31:8], next_PC[31:8], ReadData1[31:8],
                          ReadData2[31:8], result[31:8], DB[31:8]};

  assign scan_wrap_s = (scnt_r == SCAN_LAST);

  // Button synchroniser plus stability counter; cpu_clk only follows a level
  // that has been held for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_meta_r  <= 1'b0;
      sync_r       <= 1'b0;
      dcnt_r       <= '0;
      cpu_clk_r    <= 1'b0;
      step_pulse_r <= 1'b0;
    end else begin
      sync_meta_r  <= step_btn;
      sync_r       <= sync_meta_r;
      step_pulse_r <= 1'b0;
      if (sync_r == cpu_clk_r) begin
        dcnt_r <= '0;
      end else if (dcnt_r == DCNT_LAST) begin
        dcnt_r       <= '0;
        cpu_clk_r    <= sync_r;
        // Pulse only on the accepted rising level, never on release.
        step_pulse_r <= sync_r;
      end else begin
        dcnt_r <= dcnt_r + DCNT_ONE;
      end
    end
  end

  // Byte pair selected by the mode switches.
  always_comb begin
    pair_s = 16'h0000;
    case (mode_sel)
      2'b00:   pair_s = {addr[7:0], next_PC[7:0]};
      2'b01:   pair_s = {3'b000, rs_num, ReadData1[7:0]};
      2'b10:   pair_s = {3'b000, rt_num, ReadData2[7:0]};
      2'b11:   pair_s = {result[7:0], DB[7:0]};
      default: pair_s = 16'h0000;
    endcase
  end

  // Digit scan counter; the display latch only reloads at the end of the
  // last digit so a frame is never torn between two source values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scnt_r <= '0;
      idx_r  <= 2'd0;
      disp_r <= 16'h0000;
    end else if (scan_wrap_s) begin
      scnt_r <= '0;
      idx_r  <= idx_r + 2'd1;
      if (idx_r == 2'd3) begin
        disp_r <= pair_s;
      end else begin
        disp_r <= disp_r;
      end
    end else begin
      scnt_r <= scnt_r + SCAN_ONE;
    end
  end

  // Digit enable and nibble for the current scan index.
  always_comb begin
    an_nxt_s = 4'b1111;
    nib_s    = 4'h0;
    case (idx_r)
      2'd0: begin an_nxt_s = 4'b1110; nib_s = disp_r[3:0];   end
      2'd1: begin an_nxt_s = 4'b1101; nib_s = disp_r[7:4];   end
      2'd2: begin an_nxt_s = 4'b1011; nib_s = disp_r[11:8];  end
      2'd3: begin an_nxt_s = 4'b0111; nib_s = disp_r[15:12]; end
      default: begin an_nxt_s = 4'b1111; nib_s = 4'h0; end
    endcase
    seg_nxt_s = {1'b1, hex_to_seg(nib_s)};
  end

  // Registered display drivers; all digits dark while in reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      an_r  <= 4'b1111;
      seg_r <= 8'hFF;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
    end
  end

  assign cpu_clk    = cpu_clk_r;
  assign step_pulse = step_pulse_r;
  assign an         = an_r;
  assign seg        = seg_r;

endmodule

// File: tb/tb_step_display_ctrl.sv
// Self-checking bench for step_display_ctrl (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
// The reference model works from elapsed cycle counts and a sample history
// window rather than from counters mirroring the design.
module tb_step_display_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        step_btn = 1'b0;
  logic [1:0]  mode_sel = 2'b00;
  logic [4:0]  rs_num = 5'd0;
  logic [4:0]  rt_num = 5'd0;
  logic [31:0] addr = 32'h0, next_PC = 32'h0, ReadData1 = 32'h0;
  logic [31:0] ReadData2 = 32'h0, result = 32'h0, DB = 32'h0;
  logic        cpu_clk, step_pulse;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_n;
  logic [15:0]   m_disp;
  logic          m_cpu;
  logic [DEB+1:0] m_hist;
  logic [3:0]    exp_an;
  logic [7:0]    exp_seg;
  logic          exp_cpu, exp_pulse;
  logic [6:0]    hex_tab [16];

  step_display_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLK(CLK), .RST(RST), .step_btn(step_btn), .mode_sel(mode_sel),
    .rs_num(rs_num), .rt_num(rt_num), .addr(addr), .next_PC(next_PC),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .result(result), .DB(DB),
    .cpu_clk(cpu_clk), .step_pulse(step_pulse), .an(an), .seg(seg)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] pair_of(input logic [1:0] m);
    case (m)
      2'b00:   return {addr[7:0], next_PC[7:0]};
      2'b01:   return {3'b000, rs_num, ReadData1[7:0]};
      2'b10:   return {3'b000, rt_num, ReadData2[7:0]};
      default: return {result[7:0], DB[7:0]};
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0; m_disp = 16'h0000; m_cpu = 1'b0; m_hist = '0;
    exp_an = 4'hF; exp_seg = 8'hFF; exp_cpu = 1'b0; exp_pulse = 1'b0;
  endtask

  // Expected outputs after one rising edge, from what the model knew before it.
  task automatic model_edge();
    int idx;
    logic [3:0] nib;
    if (RST) begin
      idx = (m_n / SCAN_DIV) % 4;
      nib = m_disp[4*idx +: 4];
      exp_an  = ~(4'b0001 << idx);
      exp_seg = {1'b1, hex_tab[nib]};
      if (m_n % FRAME == FRAME - 1) m_disp = pair_of(mode_sel);
      m_n++;
      // Accept a level once the synchronised button (sampled two edges late)
      // has disagreed with cpu_clk for DEB consecutive edges.
      exp_pulse = 1'b0;
      if (m_hist[DEB:1] == {DEB{~m_cpu}}) begin
        m_cpu = ~m_cpu;
        exp_pulse = m_cpu;
      end
      exp_cpu = m_cpu;
      m_hist = {m_hist[DEB:0], step_btn};
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({an, seg, cpu_clk, step_pulse} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got an=%b seg=%h cpu_clk=%b pulse=%b want 1111/FF/0/0",
               an, seg, cpu_clk, step_pulse);
    end
    tick();
    tick();
    RST = 1'b1;
    tick();
    checks++;
    if (an !== 4'b1110 || seg !== 8'hC0) begin
      errors++;
      $display("FAIL reset_release got an=%b seg=%h want 1110/C0", an, seg);
    end
  endtask

  task automatic test_frame_mode00();
    logic [7:0] want_seg [4];
    want_seg = '{8'h80, 8'hF9, 8'h99, 8'hF9};
    mode_sel = 2'b00; addr = 32'h14; next_PC = 32'h18;
    for (int k = 0; k < 2 * FRAME && (k == 0 || m_n % FRAME != 0); k++) begin
      tick();
      checks++;
      if ({an, seg, cpu_clk, step_pulse} !== {exp_an, exp_seg, exp_cpu, exp_pulse}) begin
        errors++;
        $display("FAIL mode00_model got %h want %h", {an, seg, cpu_clk, step_pulse},
                 {exp_an, exp_seg, exp_cpu, exp_pulse});
      end
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (an !== ~(4'b0001 << (i / SCAN_DIV)) || seg !== want_seg[i / SCAN_DIV]) begin
        errors++;
        $display("FAIL mode00_digit%0d got an=%b seg=%h want seg=%h", i / SCAN_DIV, an, seg,
                 want_seg[i / SCAN_DIV]);
      end
    end
  endtask

  task automatic test_debounce();
    int npulse, first, fall;
    // Short bounce: must be ignored.
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) step_btn = 1'b0;
      tick();
      checks++;
      if (step_pulse !== 1'b0 || cpu_clk !== 1'b0 || cpu_clk !== exp_cpu) begin
        errors++;
        $display("FAIL bounce got cpu_clk=%b pulse=%b want 0/0", cpu_clk, step_pulse);
      end
    end
    // Long hold: exactly one pulse, DEB+2 edges after the press.
    step_btn = 1'b1; npulse = 0; first = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (step_pulse === 1'b1) begin
        npulse++;
        if (first < 0) first = i;
      end
      checks++;
      if ({cpu_clk, step_pulse} !== {exp_cpu, exp_pulse}) begin
        errors++;
        $display("FAIL hold_model got %b%b want %b%b", cpu_clk, step_pulse, exp_cpu, exp_pulse);
      end
    end
    checks++;
    if (npulse != 1 || first != DEB + 2 || cpu_clk !== 1'b1) begin
      errors++;
      $display("FAIL hold_pulse got count=%0d at=%0d cpu_clk=%b want 1/%0d/1",
               npulse, first, cpu_clk, DEB + 2);
    end
    // Release: cpu_clk falls DEB+2 edges later, no pulse.
    step_btn = 1'b0; npulse = 0; fall = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (step_pulse === 1'b1) npulse++;
      if (fall < 0 && cpu_clk === 1'b0) fall = i;
    end
    checks++;
    if (npulse != 0 || fall != DEB + 2) begin
      errors++;
      $display("FAIL release got pulses=%0d fall_at=%0d want 0/%0d", npulse, fall, DEB + 2);
    end
  endtask

  task automatic test_no_tearing();
    logic [7:0] want_seg [4];
    want_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    mode_sel = 2'b11; result = 32'h1234_56AB; DB = 32'h9876_54CD;
    for (int k = 0; k < 2 * FRAME && (k == 0 || m_n % FRAME != 0); k++) tick();
    for (int i = 0; i < 2 * FRAME; i++) begin
      // Switch source at digit 1 of the second frame; the old pair must persist.
      if (i == FRAME + SCAN_DIV) begin
        mode_sel = 2'b01; rs_num = 5'd31; ReadData1 = 32'h0000_00FF;
      end
      tick();
      checks++;
      if (seg !== want_seg[(i % FRAME) / SCAN_DIV]) begin
        errors++;
        $display("FAIL tear_frame%0d_digit%0d got seg=%h want %h", i / FRAME,
                 (i % FRAME) / SCAN_DIV, seg, want_seg[(i % FRAME) / SCAN_DIV]);
      end
    end
  endtask

  task automatic test_mode01_ff();
    logic [7:0] want_seg [4];
    want_seg = '{8'h8E, 8'h8E, 8'h8E, 8'hF9};
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (seg !== want_seg[i / SCAN_DIV] || seg !== exp_seg) begin
        errors++;
        $display("FAIL mode01_digit%0d got seg=%h want %h", i / SCAN_DIV, seg,
                 want_seg[i / SCAN_DIV]);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int npulse, first;
    step_btn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    RST = 1'b0;
    model_reset();
    #1;
    checks++;
    if (cpu_clk !== 1'b0 || step_pulse !== 1'b0 || an !== 4'hF) begin
      errors++;
      $display("FAIL midreset_state got cpu_clk=%b pulse=%b an=%b want 0/0/1111",
               cpu_clk, step_pulse, an);
    end
    tick();
    tick();
    RST = 1'b1;
    npulse = 0; first = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (step_pulse === 1'b1) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (npulse != 1 || first != DEB + 2) begin
      errors++;
      $display("FAIL midreset_pulse got count=%0d at=%0d want 1/%0d", npulse, first, DEB + 2);
    end
    step_btn = 1'b0;
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_random();
    int hold_left;
    hold_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_left == 0) begin
        step_btn  = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 20);
      end
      hold_left--;
      if ($urandom_range(0, 6) == 0) mode_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        addr = $urandom(); next_PC = $urandom(); ReadData1 = $urandom();
        ReadData2 = $urandom(); result = $urandom(); DB = $urandom();
        rs_num = 5'($urandom()); rt_num = 5'($urandom());
      end
      if ($urandom_range(0, 399) == 0) begin
        RST = 1'b0;
        model_reset();
      end else begin
        RST = 1'b1;
      end
      tick();
      checks++;
      if ({an, seg, cpu_clk, step_pulse} !== {exp_an, exp_seg, exp_cpu, exp_pulse}) begin
        errors++;
        $display("FAIL random_cycle%0d got an=%b seg=%h clk=%b pulse=%b want %b/%h/%b/%b",
                 i, an, seg, cpu_clk, step_pulse, exp_an, exp_seg, exp_cpu, exp_pulse);
      end
    end
    RST = 1'b1;
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    model_reset();
    test_reset();
    test_frame_mode00();
    test_debounce();
    test_no_tearing();
    test_mode01_ff();
    test_reset_mid_press();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
